// File: rtl/pc_gen.sv
// pc_gen: RISC-V program counter generator with boot, run and hold states.
// Selects the next fetch address from sequential advance, branch, jalr,
// mret and trap redirects, holding a pending target across fetch stalls.
//
// Parameters:
//   XLEN      address / PC width
//   RESET_VEC PC value loaded on reset
//   TRAP_VEC  target for traps and misaligned redirects
//   IALIGN    instruction alignment in bytes (2 or 4)
//
// Ports:
//   clk, rst      clock (rising edge), async active-high reset
//   stall         hold PC, no advance
//   pc_ready      fetch accepts current pc_out
//   br_taken      PC-relative branch/JAL, target pc_out + br_offset
//   jalr_taken    indirect jump, target (jalr_base + jalr_offset) & ~1
//   trap_req      trap, target TRAP_VEC, ignores stall/pc_ready
//   mret_req      return from trap, target mepc_in
//   pc_out        current fetch address
//   pc_valid      pc_out valid for fetch (low in BOOT)
//   misalign_exc  one-cycle pulse on a misaligned redirect target
//   bad_addr      last misaligned target
//
// Build option:
//   PC_MISALIGN_TRAP_EN  defined: misaligned targets trap to TRAP_VEC and
//                        are reported on misalign_exc/bad_addr.
//                        undefined: targets are aligned down to IALIGN and
//                        misalign_exc/bad_addr are tied to zero.

module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_offset,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mepc_in,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_exc,
  output logic [XLEN-1:0] bad_addr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_pend;
  logic [XLEN-1:0] w_pend_nxt;

  logic            w_go;
  logic            w_redir;
  logic            w_apply;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_raw_tgt;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_app_tgt;
  logic [XLEN-1:0] w_apply_pc;

  assign w_go       = pc_ready & ~stall;
  assign w_redir    = mret_req | jalr_taken | br_taken;
  assign w_jalr_sum = jalr_base + jalr_offset;
  assign w_br_tgt   = r_pc + br_offset;

  // Non-trap redirect priority: mret > jalr > branch.
  always_comb begin
    w_raw_tgt = w_br_tgt;
    if (mret_req) begin
      w_raw_tgt = mepc_in;
    end else if (jalr_taken) begin
      w_raw_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign w_tgt = w_raw_tgt;
`else
  assign w_tgt = w_raw_tgt & ~ALIGN_MASK;
`endif

  // In HOLD a same-cycle redirect is newer than the pending one.
  assign w_app_tgt =
    (r_state == HOLD && !w_redir) ? r_pend : w_tgt;

  // A redirect (fresh in RUN, fresh or pending in HOLD) lands this edge.
  assign w_apply = ~trap_req & w_go &
    ((r_state == RUN && w_redir) || r_state == HOLD);

`ifdef PC_MISALIGN_TRAP_EN
  logic            r_mis;
  logic            w_mis_nxt;
  logic [XLEN-1:0] r_bad;
  logic [XLEN-1:0] w_bad_nxt;
  logic            w_app_bad;

  assign w_app_bad  = |(w_app_tgt & ALIGN_MASK);
  assign w_apply_pc = w_app_bad ? TRAP_VEC : w_app_tgt;
  assign w_mis_nxt  = w_apply & w_app_bad;
  assign w_bad_nxt  = w_mis_nxt ? w_app_tgt : r_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis <= 1'b0;
      r_bad <= '0;
    end else begin
      r_mis <= w_mis_nxt;
      r_bad <= w_bad_nxt;
    end
  end

  assign misalign_exc = r_mis;
  assign bad_addr     = r_bad;
`else
  assign w_apply_pc   = w_app_tgt;
  assign misalign_exc = 1'b0;
  assign bad_addr     = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    if (trap_req) begin
      w_state_nxt = RUN;
      w_pc_nxt    = TRAP_VEC;
      w_pend_nxt  = '0;
    end else begin
      case (r_state)
        BOOT: begin
          w_state_nxt = RUN;
        end
        RUN: begin
          if (w_apply) begin
            w_pc_nxt = w_apply_pc;
          end else if (w_redir) begin
            w_pend_nxt  = w_tgt;
            w_state_nxt = HOLD;
          end else if (w_go) begin
            w_pc_nxt = r_pc + PC_STEP;
          end
        end
        HOLD: begin
          if (w_apply) begin
            w_pc_nxt    = w_apply_pc;
            w_pend_nxt  = '0;
            w_state_nxt = RUN;
          end else if (w_redir) begin
            w_pend_nxt = w_tgt;
          end
        end
        default: begin
          w_state_nxt = BOOT;
          w_pc_nxt    = RESET_VEC;
          w_pend_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_VEC;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign pc_out   = r_pc;
  assign pc_valid = (r_state != BOOT);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a
// behavioural next-PC model.

module tb_pc_gen;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0;
  localparam logic [31:0] TV   = 32'h0000_0100;
  localparam int          IA   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pc_ready;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jalr_taken;
  logic [31:0] jalr_base;
  logic [31:0] jalr_offset;
  logic        trap_req;
  logic        mret_req;
  logic [31:0] mepc_in;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        misalign_exc;
  logic [31:0] bad_addr;

  pc_gen #(
    .XLEN(XLEN), .RESET_VEC(RV), .TRAP_VEC(TV), .IALIGN(IA)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_ready(pc_ready),
    .br_taken(br_taken), .br_offset(br_offset),
    .jalr_taken(jalr_taken), .jalr_base(jalr_base),
    .jalr_offset(jalr_offset), .trap_req(trap_req),
    .mret_req(mret_req), .mepc_in(mepc_in), .pc_out(pc_out),
    .pc_valid(pc_valid), .misalign_exc(misalign_exc),
    .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_bad;
  bit          m_booted;
  bit          m_hold;
  bit          m_mis;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc     = RV;
    m_pend   = '0;
    m_bad    = '0;
    m_booted = 0;
    m_hold   = 0;
    m_mis    = 0;
  endtask

  task automatic m_apply(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    if (t % IA != 0) begin
      m_pc  = TV;
      m_mis = 1;
      m_bad = t;
    end else begin
      m_pc = t;
    end
`else
    m_pc = t;
`endif
  endtask

  // Next fetch address from the current inputs, one call per clock edge.
  task automatic model_step();
    logic [31:0] t;
    bit redir;
    bit go;
    m_mis = 0;
    if (trap_req) begin
      m_pc     = TV;
      m_hold   = 0;
      m_booted = 1;
      return;
    end
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    redir = mret_req || jalr_taken || br_taken;
    go    = pc_ready && !stall;
    if (mret_req)        t = mepc_in;
    else if (jalr_taken) t = (jalr_base + jalr_offset) & ~32'h1;
    else                 t = m_pc + br_offset;
`ifndef PC_MISALIGN_TRAP_EN
    t = t - (t % IA);
`endif
    if (m_hold) begin
      if (redir) m_pend = t;
      if (go) begin
        m_hold = 0;
        m_apply(m_pend);
      end
    end else if (redir) begin
      if (go) m_apply(t);
      else begin
        m_hold = 1;
        m_pend = t;
      end
    end else if (go) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare();
    chk("pc_out", pc_out, m_pc);
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_booted});
    chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, m_mis});
    chk("bad_addr", bad_addr, m_bad);
  endtask

  task automatic idle();
    stall       = 0;
    pc_ready    = 1;
    br_taken    = 0;
    br_offset   = '0;
    jalr_taken  = 0;
    jalr_base   = '0;
    jalr_offset = '0;
    trap_req    = 0;
    mret_req    = 0;
    mepc_in     = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic go_to(input logic [31:0] a);
    idle();
    mret_req = 1;
    mepc_in  = a;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    m_reset();
    #2;
    chk("rst_pc", pc_out, RV);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    @(negedge clk);
    rst = 0;
    chk("boot_valid", {31'b0, pc_valid}, 32'h0);

    // Boot then sequential fetch.
    cyc(); chk("seq0", pc_out, 32'h0);
    chk("run_valid", {31'b0, pc_valid}, 32'h1);
    cyc(); chk("seq4", pc_out, 32'h4);
    cyc(); chk("seq8", pc_out, 32'h8);
    cyc(); cyc(); chk("seq10", pc_out, 32'h10);

    // Backward branch, then jalr beating a branch.
    br_taken = 1; br_offset = 32'hFFFF_FFF8;
    cyc(); chk("br_back", pc_out, 32'h8);
    jalr_taken = 1; jalr_base = 32'h200; jalr_offset = 32'h5;
    cyc(); chk("jalr_prio", pc_out, 32'h204);

    // Branch under fetch back-pressure.
    go_to(32'h40);
    pc_ready = 0; br_taken = 1; br_offset = 32'h20;
    cyc(); chk("hold_keep", pc_out, 32'h40);
    idle(); pc_ready = 0;
    cyc(); chk("hold_keep2", pc_out, 32'h40);
    idle();
    cyc(); chk("hold_rel", pc_out, 32'h60);

    // Trap overrides a stalled pending redirect.
    go_to(32'h40);
    pc_ready = 0; br_taken = 1; br_offset = 32'h20;
    cyc(); chk("hold2", pc_out, 32'h40);
    idle(); stall = 1; trap_req = 1;
    cyc(); chk("trap", pc_out, 32'h100);
    idle();
    cyc(); chk("trap_nopend", pc_out, 32'h104);

    // Misaligned branch target 0x1002.
    br_taken = 1; br_offset = 32'h0000_0EFE;
    cyc();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_exc", {31'b0, misalign_exc}, 32'h1);
    chk("mis_bad", bad_addr, 32'h1002);
`else
    chk("mis_pc", pc_out, 32'h1000);
    chk("mis_exc", {31'b0, misalign_exc}, 32'h0);
`endif
    idle();
    cyc(); chk("mis_pulse", {31'b0, misalign_exc}, 32'h0);

    // Wrap, then async reset mid-HOLD.
    go_to(32'hFFFF_FFFC);
    cyc(); chk("wrap", pc_out, 32'h0);
    pc_ready = 0; br_taken = 1; br_offset = 32'h80;
    cyc(); chk("hold3", pc_out, 32'h0);
    idle();
    #2 rst = 1;
    m_reset();
    #1;
    chk("arst_pc", pc_out, RV);
    chk("arst_valid", {31'b0, pc_valid}, 32'h0);
    @(negedge clk);
    rst = 0;
    cyc(); chk("arst_boot", pc_out, RV);
    cyc(); chk("arst_nopend", pc_out, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      pc_ready   = ($urandom_range(0, 3) != 0);
      br_taken   = ($urandom_range(0, 3) == 0);
      jalr_taken = ($urandom_range(0, 5) == 0);
      mret_req   = ($urandom_range(0, 7) == 0);
      trap_req   = ($urandom_range(0, 24) == 0);
      br_offset  = $urandom_range(0, 1) ?
                   (32'($urandom_range(0, 63)) << 1) :
                   -(32'($urandom_range(0, 63)) << 1);
      jalr_base  = $urandom;
      jalr_offset = 32'($urandom_range(0, 15));
      mepc_in    = ($urandom_range(0, 9) == 0) ?
                   32'hFFFF_FFF0 : $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1;
        m_reset();
        #1;
        compare();
        rst = 0;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
